irq_controller: RTL and testbench

- Multi-source external interrupt controller in front of processor_arm.
- Edge-detects NSRC peripheral requests, latches them as pending and applies a software mask.
- Selects one source by fixed priority (lowest index wins) and drives the processor's single ExtIRQ line.
- Holds ExtIRQ until ExtIAck, then blocks further requests until the handler signals end-of-interrupt (eoi). No nesting.

---
 rtl/irq_ctrl_pkg.sv | 13 +
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_controller.sv | 134 +++++++++++++
 tb/tb_irq_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and default sizing for the external interrupt controller.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StService
    } irq_state_e;

    localparam int unsigned NSRC_DEFAULT   = 8;
    localparam int unsigned ACK_TO_DEFAULT = 64;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit index of a request vector.
module irq_prio_enc #(
    parameter int unsigned NSRC = 8,
    parameter int unsigned IDW  = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] i_vec,
    output logic            o_valid,
    output logic [IDW-1:0]  o_idx
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDW'(i);
            end
        end
    end

    assign o_valid = |i_vec;

endmodule

// File: rtl/irq_controller.sv
// External interrupt controller: edge-detected pending requests, mask, fixed
// priority and a single non-nesting request/acknowledge/eoi handshake.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NSRC   = NSRC_DEFAULT,
    parameter int unsigned IDW    = $clog2(NSRC),
    parameter int unsigned ACK_TO = ACK_TO_DEFAULT
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            ExtIAck,
    input  logic            eoi,
    output logic            ExtIRQ,
    output logic [IDW-1:0]  irq_id,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask,
    output logic            busy,
    output logic            timeout_err
);

    localparam int unsigned CW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TO - 1);

    irq_state_e      r_state;
    irq_state_e      w_state_d;
    logic [NSRC-1:0] r_hist;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic [IDW-1:0]  r_irq_id;
    logic [CW-1:0]   r_cnt;
    logic            r_ext_irq;
    logic            r_timeout_err;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_mask_eff;
    logic [NSRC-1:0] w_eligible;
    logic            w_elig_valid;
    logic [IDW-1:0]  w_elig_idx;
    logic [IDW-1:0]  w_irq_id_d;
    logic [CW-1:0]   w_cnt_d;
    logic            w_ext_irq_d;
    logic            w_to_set;

    assign w_rise     = irq_src & ~r_hist;
    assign w_mask_eff = mask_we ? mask_wdata : r_mask;
    assign w_eligible = r_pending & r_mask;

    irq_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio_enc (
        .i_vec   (w_eligible),
        .o_valid (w_elig_valid),
        .o_idx   (w_elig_idx)
    );

    always_comb begin
        w_state_d   = r_state;
        w_irq_id_d  = r_irq_id;
        w_cnt_d     = r_cnt;
        w_ext_irq_d = 1'b0;
        w_clr       = '0;
        w_to_set    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_elig_valid) begin
                    w_state_d   = StReq;
                    w_irq_id_d  = w_elig_idx;
                    w_cnt_d     = '0;
                    w_ext_irq_d = 1'b1;
                end
            end
            StReq: begin
                // Ack wins over a same-cycle withdraw or timeout.
                if (ExtIAck) begin
                    w_state_d        = StService;
                    w_clr[r_irq_id]  = 1'b1;
                end else if (!w_mask_eff[r_irq_id]) begin
                    w_state_d = StIdle;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_d = StIdle;
                    w_to_set  = 1'b1;
                end else begin
                    w_cnt_d     = r_cnt + 1'b1;
                    w_ext_irq_d = 1'b1;
                end
            end
            StService: begin
                if (eoi) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state       <= StIdle;
            r_hist        <= '0;
            r_pending     <= '0;
            r_mask        <= '1;
            r_irq_id      <= '0;
            r_cnt         <= '0;
            r_ext_irq     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_hist        <= irq_src;
            // A new edge on the source being cleared must not be lost.
            r_pending     <= (r_pending & ~w_clr) | w_rise;
            r_mask        <= w_mask_eff;
            r_irq_id      <= w_irq_id_d;
            r_cnt         <= w_cnt_d;
            r_ext_irq     <= w_ext_irq_d;
            r_timeout_err <= r_timeout_err | w_to_set;
        end
    end

    assign ExtIRQ      = r_ext_irq;
    assign irq_id      = r_irq_id;
    assign pending     = r_pending;
    assign mask        = r_mask;
    assign busy        = (r_state == StService);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a per-cycle reference model.
module tb_irq_controller;

    localparam int NSRC   = 8;
    localparam int IDW    = 3;
    localparam int ACK_TO = 64;

    logic            CLOCK_50 = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq_src;
    logic            mask_we;
    logic [NSRC-1:0] mask_wdata;
    logic            ExtIAck;
    logic            eoi;
    logic            ExtIRQ;
    logic [IDW-1:0]  irq_id;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;
    logic            busy;
    logic            timeout_err;

    always #5 CLOCK_50 = ~CLOCK_50;

    irq_controller #(
        .NSRC   (NSRC),
        .IDW    (IDW),
        .ACK_TO (ACK_TO)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .irq_src     (irq_src),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .ExtIAck     (ExtIAck),
        .eoi         (eoi),
        .ExtIRQ      (ExtIRQ),
        .irq_id      (irq_id),
        .pending     (pending),
        .mask        (mask),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Reference model: phase 0 = idle, 1 = requesting, 2 = in handler.
    logic [NSRC-1:0] m_pend, m_mask, m_hist;
    int              m_phase, m_id, m_wait;
    bit              m_terr;
    bit              m_init = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Literal expectation mailbox, written by stimulus, consumed by checker.
    int    lit_req = 0;
    int    lit_done = 0;
    string lit_name;
    logic [31:0] lit_val;

    function automatic int lowest(input logic [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] pack(input logic irq, input int id, input logic [NSRC-1:0] pnd,
                                         input logic [NSRC-1:0] msk, input logic bsy,
                                         input logic terr);
        logic [IDW-1:0] id_b;
        id_b = id[IDW-1:0];
        return {10'd0, irq, id_b, pnd, msk, bsy, terr};
    endfunction

    task automatic model_advance();
        logic [NSRC-1:0] rise, nmask;
        if (reset) begin
            m_pend = '0; m_mask = '1; m_hist = '0;
            m_phase = 0; m_id = 0; m_wait = 0; m_terr = 1'b0; m_init = 1'b1;
            return;
        end
        if (!m_init) return;
        rise   = irq_src & ~m_hist;
        m_hist = irq_src;
        nmask  = mask_we ? mask_wdata : m_mask;
        if (m_phase == 0) begin
            if ((m_pend & m_mask) != '0) begin
                m_id = lowest(m_pend & m_mask);
                m_phase = 1;
                m_wait = 1;
            end
        end else if (m_phase == 1) begin
            if (ExtIAck) begin
                m_pend[m_id] = 1'b0;
                m_phase = 2;
            end else if (!nmask[m_id]) begin
                m_phase = 0;
            end else if (m_wait == ACK_TO) begin
                m_phase = 0;
                m_terr = 1'b1;
            end else begin
                m_wait++;
            end
        end else if (eoi) begin
            m_phase = 0;
        end
        m_pend = m_pend | rise;
        m_mask = nmask;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Checker: every negedge after the model has seen reset.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (m_init) begin
                cmp("ExtIRQ", 32'(ExtIRQ), 32'(m_phase == 1));
                cmp("irq_id", 32'(irq_id), 32'(m_id));
                cmp("pending", 32'(pending), 32'(m_pend));
                cmp("mask", 32'(mask), 32'(m_mask));
                cmp("busy", 32'(busy), 32'(m_phase == 2));
                cmp("timeout_err", 32'(timeout_err), 32'(m_terr));
            end
            if (lit_req != lit_done) begin
                cmp({lit_name, " dut"}, pack(ExtIRQ, int'(irq_id), pending, mask, busy,
                                             timeout_err), lit_val);
                cmp({lit_name, " model"}, pack(m_phase == 1, m_id, m_pend, m_mask, m_phase == 2,
                                               m_terr), lit_val);
                lit_done = lit_req;
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            model_advance();
            #1;
        end
    endtask

    task automatic expect_lit(input string name, input logic irq, input int id,
                              input logic [NSRC-1:0] pnd, input logic [NSRC-1:0] msk,
                              input logic bsy, input logic terr);
        lit_name = name;
        lit_val  = pack(irq, id, pnd, msk, bsy, terr);
        lit_req++;
    endtask

    task automatic ack_then_eoi();
        ExtIAck = 1'b1;
        step();
        ExtIAck = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_src = '0; mask_we = 1'b0; mask_wdata = '0;
        ExtIAck = 1'b0; eoi = 1'b0;
        step(2);
        reset = 1'b0;
        expect_lit("reset", 1'b0, 0, 8'h00, 8'hFF, 1'b0, 1'b0);

        // 1: single source, full handshake
        irq_src = 8'h08;
        step();
        expect_lit("t1 pend", 1'b0, 0, 8'h08, 8'hFF, 1'b0, 1'b0);
        step();
        expect_lit("t1 req", 1'b1, 3, 8'h08, 8'hFF, 1'b0, 1'b0);
        ExtIAck = 1'b1;
        step();
        ExtIAck = 1'b0;
        expect_lit("t1 ack", 1'b0, 3, 8'h00, 8'hFF, 1'b1, 1'b0);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        expect_lit("t1 eoi", 1'b0, 3, 8'h00, 8'hFF, 1'b0, 1'b0);
        irq_src = 8'h00;
        step(2);

        // 2: simultaneous sources, lowest index first
        irq_src = 8'h22;
        step(2);
        expect_lit("t2 req1", 1'b1, 1, 8'h22, 8'hFF, 1'b0, 1'b0);
        ack_then_eoi();
        expect_lit("t2 idle", 1'b0, 1, 8'h20, 8'hFF, 1'b0, 1'b0);
        step();
        expect_lit("t2 req5", 1'b1, 5, 8'h20, 8'hFF, 1'b0, 1'b0);
        ack_then_eoi();
        irq_src = 8'h00;
        step();

        // 3: mask-off withdraws, unmask re-presents
        irq_src = 8'h08;
        step(2);
        mask_we = 1'b1; mask_wdata = 8'hF7;
        step();
        mask_we = 1'b0;
        expect_lit("t3 masked", 1'b0, 3, 8'h08, 8'hF7, 1'b0, 1'b0);
        step();
        mask_we = 1'b1; mask_wdata = 8'hFF;
        step();
        mask_we = 1'b0;
        step();
        expect_lit("t3 re", 1'b1, 3, 8'h08, 8'hFF, 1'b0, 1'b0);
        ack_then_eoi();
        irq_src = 8'h00;
        step();

        // 4: acknowledge timeout
        irq_src = 8'h10;
        step(2);
        step(ACK_TO - 1);
        expect_lit("t4 still", 1'b1, 4, 8'h10, 8'hFF, 1'b0, 1'b0);
        step();
        expect_lit("t4 timeout", 1'b0, 4, 8'h10, 8'hFF, 1'b0, 1'b1);
        step();
        expect_lit("t4 rereq", 1'b1, 4, 8'h10, 8'hFF, 1'b0, 1'b1);
        ack_then_eoi();
        irq_src = 8'h00;
        step();

        // 5: re-rise during service, and set-wins on ack
        irq_src = 8'h04;
        step(2);
        ExtIAck = 1'b1;
        step();
        ExtIAck = 1'b0;
        irq_src = 8'h00;
        step();
        irq_src = 8'h04;
        step();
        expect_lit("t5 rerise", 1'b0, 2, 8'h04, 8'hFF, 1'b1, 1'b1);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
        expect_lit("t5 again", 1'b1, 2, 8'h04, 8'hFF, 1'b0, 1'b1);
        irq_src = 8'h00;
        step();
        irq_src = 8'h04; ExtIAck = 1'b1;
        step();
        ExtIAck = 1'b0;
        expect_lit("t5 setwins", 1'b0, 2, 8'h04, 8'hFF, 1'b1, 1'b1);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
        ack_then_eoi();
        irq_src = 8'h00;
        step();

        // 6: reset mid-request, held source re-registers once
        irq_src = 8'h24;
        step(2);
        expect_lit("t6 req", 1'b1, 2, 8'h24, 8'hFF, 1'b0, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_lit("t6 reset", 1'b0, 0, 8'h00, 8'hFF, 1'b0, 1'b0);
        step();
        expect_lit("t6 post", 1'b0, 0, 8'h24, 8'hFF, 1'b0, 1'b0);
        step();
        expect_lit("t6 rereq", 1'b1, 2, 8'h24, 8'hFF, 1'b0, 1'b0);
        ack_then_eoi();
        // spurious handshakes outside their states are ignored
        ExtIAck = 1'b1; eoi = 1'b1;
        step();
        ExtIAck = 1'b0; eoi = 1'b0;
        step(3);
        @(negedge CLOCK_50);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
